// File: rtl/led_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : led_sequencer
// Brief    : Prescaled WIDTH-bit LED pattern generator with four selectable
//            modes (count, rotate, bounce, PWM breathe) plus pause/single-step.
// Revision : 1.0
// ============================================================================
module led_sequencer #(
    parameter int WIDTH    = 5,
    parameter int DIV      = 2000000,
    parameter int PWM_BITS = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [1:0]       MODE,
    input  logic             ENABLE,
    input  logic             STEP,
    output logic [WIDTH-1:0] LEDS,
    output logic             TICK
);

    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int POS_W = $clog2(WIDTH);

    localparam logic [PRE_W-1:0]    c_PRE_LAST = PRE_W'(DIV - 1);
    localparam logic [POS_W-1:0]    c_POS_LAST = POS_W'(WIDTH - 1);
    localparam logic [PWM_BITS-1:0] c_LVL_MAX  = '1;
    localparam logic [WIDTH-1:0]    c_ONE      = WIDTH'(1);

    typedef enum logic [1:0] {
        MODE_COUNT   = 2'd0,
        MODE_ROTATE  = 2'd1,
        MODE_BOUNCE  = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_t;

    mode_t               r_mode_q;
    logic                r_mode_chg;
    logic                r_step_q;
    logic                r_tick;
    logic [PRE_W-1:0]    r_pre;
    logic [WIDTH-1:0]    r_count;
    logic [WIDTH-1:0]    r_onehot;
    logic [POS_W-1:0]    r_pos;
    logic                r_dir_down;
    logic [PWM_BITS-1:0] r_level;
    logic                r_ldir_down;
    logic [PWM_BITS-1:0] r_pwm;
    logic [WIDTH-1:0]    r_leds;

    logic                w_wrap;
    logic                w_adv;
    logic [PRE_W-1:0]    w_pre_nxt;
    logic [WIDTH-1:0]    w_count_nxt;
    logic [WIDTH-1:0]    w_onehot_nxt;
    logic [POS_W-1:0]    w_pos_nxt;
    logic                w_dir_down_nxt;
    logic [PWM_BITS-1:0] w_level_nxt;
    logic                w_ldir_down_nxt;
    logic [WIDTH-1:0]    w_leds_nxt;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_mode_q    <= MODE_COUNT;
            r_mode_chg  <= 1'b0;
            r_step_q    <= 1'b0;
            r_tick      <= 1'b0;
            r_pre       <= '0;
            r_count     <= '0;
            r_onehot    <= c_ONE;
            r_pos       <= '0;
            r_dir_down  <= 1'b0;
            r_level     <= '0;
            r_ldir_down <= 1'b0;
            r_pwm       <= '0;
            r_leds      <= '0;
        end else begin
            r_mode_q    <= mode_t'(MODE);
            r_mode_chg  <= (MODE != r_mode_q);
            r_step_q    <= STEP;
            r_tick      <= w_wrap;
            r_pre       <= w_pre_nxt;
            r_count     <= w_count_nxt;
            r_onehot    <= w_onehot_nxt;
            r_pos       <= w_pos_nxt;
            r_dir_down  <= w_dir_down_nxt;
            r_level     <= w_level_nxt;
            r_ldir_down <= w_ldir_down_nxt;
            r_pwm       <= r_pwm + PWM_BITS'(1);
            r_leds      <= w_leds_nxt;
        end
    end

    // A single-step is honoured only while paused, so a free-running pattern
    // can never be double-advanced by a stray button press.
    always_comb begin
        w_wrap    = ENABLE && (r_pre == c_PRE_LAST);
        w_adv     = w_wrap || (STEP && !r_step_q && !ENABLE);
        w_pre_nxt = r_pre;
        if (ENABLE) begin
            w_pre_nxt = w_wrap ? '0 : r_pre + PRE_W'(1);
        end
    end

    always_comb begin
        w_count_nxt     = r_count;
        w_onehot_nxt    = r_onehot;
        w_pos_nxt       = r_pos;
        w_dir_down_nxt  = r_dir_down;
        w_level_nxt     = r_level;
        w_ldir_down_nxt = r_ldir_down;

        // The delayed change flag gives the re-init priority over any advance.
        if (r_mode_chg) begin
            case (r_mode_q)
                MODE_COUNT:   w_count_nxt = '0;
                MODE_ROTATE:  w_onehot_nxt = c_ONE;
                MODE_BOUNCE: begin
                    w_pos_nxt      = '0;
                    w_dir_down_nxt = 1'b0;
                end
                MODE_BREATHE: begin
                    w_level_nxt     = '0;
                    w_ldir_down_nxt = 1'b0;
                end
            endcase
        end else if (w_adv) begin
            case (r_mode_q)
                MODE_COUNT:   w_count_nxt = r_count + WIDTH'(1);
                MODE_ROTATE:  w_onehot_nxt = {r_onehot[WIDTH-2:0], r_onehot[WIDTH-1]};
                MODE_BOUNCE: begin
                    if (r_dir_down) begin
                        w_pos_nxt = r_pos - POS_W'(1);
                        if (w_pos_nxt == '0) w_dir_down_nxt = 1'b0;
                    end else begin
                        w_pos_nxt = r_pos + POS_W'(1);
                        if (w_pos_nxt == c_POS_LAST) w_dir_down_nxt = 1'b1;
                    end
                end
                MODE_BREATHE: begin
                    if (r_ldir_down) begin
                        w_level_nxt = r_level - PWM_BITS'(1);
                        if (w_level_nxt == '0) w_ldir_down_nxt = 1'b0;
                    end else begin
                        w_level_nxt = r_level + PWM_BITS'(1);
                        if (w_level_nxt == c_LVL_MAX) w_ldir_down_nxt = 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        w_leds_nxt = '0;
        case (r_mode_q)
            MODE_COUNT:   w_leds_nxt = w_count_nxt;
            MODE_ROTATE:  w_leds_nxt = w_onehot_nxt;
            MODE_BOUNCE:  w_leds_nxt = c_ONE << w_pos_nxt;
            MODE_BREATHE: w_leds_nxt = (r_pwm < w_level_nxt) ? '1 : '0;
        endcase
    end

    assign LEDS = r_leds;
    assign TICK = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_led_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_sequencer
// Brief    : Self-checking bench for led_sequencer against a step-index model.
// Revision : 1.0
// ============================================================================
module tb_led_sequencer;

    localparam int W  = 5;
    localparam int D  = 4;
    localparam int PB = 2;

    logic         CLK = 1'b0;
    logic         RESET = 1'b0;
    logic [1:0]   MODE = 2'd0;
    logic         ENABLE = 1'b0;
    logic         STEP = 1'b0;
    logic [W-1:0] LEDS;
    logic         TICK;

    int checks = 0;
    int errors = 0;

    // Model: each mode's pattern is a pure function of how many advances it
    // has received since its last re-init.
    int           m_pre;
    int           m_mq;
    int           m_pwm;
    int           m_k[4];
    bit           m_chg;
    bit           m_sq;
    logic [W-1:0] exp_leds;
    logic         exp_tick;

    led_sequencer #(.WIDTH(W), .DIV(D), .PWM_BITS(PB)) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .MODE   (MODE),
        .ENABLE (ENABLE),
        .STEP   (STEP),
        .LEDS   (LEDS),
        .TICK   (TICK)
    );

    always #5 CLK = ~CLK;

    function automatic logic [W-1:0] pat(input int m, input int k, input int pwm);
        int p;
        int lvl;
        int lmax;
        logic [W-1:0] one;
        one  = 1;
        lmax = (1 << PB) - 1;
        pat  = '0;
        case (m)
            0: pat = W'(k % (1 << W));
            1: pat = one << (k % W);
            2: begin
                p   = k % (2 * (W - 1));
                pat = one << ((p <= W - 1) ? p : 2 * (W - 1) - p);
            end
            default: begin
                p   = k % (2 * lmax);
                lvl = (p <= lmax) ? p : 2 * lmax - p;
                pat = (pwm < lvl) ? '1 : '0;
            end
        endcase
    endfunction

    task automatic m_reset();
        m_pre = 0; m_mq = 0; m_pwm = 0; m_chg = 0; m_sq = 0;
        for (int i = 0; i < 4; i++) m_k[i] = 0;
        exp_leds = '0;
        exp_tick = 1'b0;
    endtask

    task automatic cyc();
        bit adv;
        @(posedge CLK);
        if (RESET) begin
            m_reset();
        end else begin
            adv      = (m_pre == D - 1 && ENABLE) || (STEP && !m_sq && !ENABLE);
            exp_tick = (m_pre == D - 1) && ENABLE;
            if (ENABLE) m_pre = (m_pre + 1) % D;
            if (m_chg) m_k[m_mq] = 0;
            else if (adv) m_k[m_mq] = m_k[m_mq] + 1;
            exp_leds = pat(m_mq, m_k[m_mq], m_pwm);
            m_pwm    = (m_pwm + 1) % (1 << PB);
            m_sq     = STEP;
            m_chg    = (int'(MODE) != m_mq);
            m_mq     = int'(MODE);
        end
        @(negedge CLK);
    endtask

    task automatic test_reset();
        ENABLE = 1'b1;
        MODE   = 2'd0;
        repeat (7) cyc();
        #2 RESET = 1'b1;
        m_reset();
        #1;
        checks++;
        if (LEDS !== '0) begin errors++; $display("FAIL reset_leds got %b want 0", LEDS); end
        checks++;
        if (TICK !== 1'b0) begin errors++; $display("FAIL reset_tick got %b want 0", TICK); end
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic test_count();
        int last_tick;
        bit saw_wrap;
        logic [W-1:0] prev;
        last_tick = -1;
        saw_wrap  = 1'b0;
        prev      = '0;
        for (int c = 0; c < 140; c++) begin
            cyc();
            checks++;
            if (LEDS !== exp_leds) begin errors++; $display("FAIL count_leds c=%0d got %0d want %0d", c, LEDS, exp_leds); end
            checks++;
            if (TICK !== exp_tick) begin errors++; $display("FAIL count_tick c=%0d got %b want %b", c, TICK, exp_tick); end
            if (TICK === 1'b1) begin
                if (last_tick >= 0) begin
                    checks++;
                    if (c - last_tick != D) begin errors++; $display("FAIL tick_period got %0d want %0d", c - last_tick, D); end
                end
                last_tick = c;
            end
            if (prev == 5'd31 && LEDS == 5'd0) saw_wrap = 1'b1;
            prev = LEDS;
        end
        checks++;
        if (saw_wrap !== 1'b1) begin errors++; $display("FAIL count_wrap got %b want 1", saw_wrap); end
    endtask

    task automatic test_rotate();
        logic [W-1:0] tbl[5] = '{5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
        int n;
        MODE   = 2'd1;
        ENABLE = 1'b1;
        cyc(); cyc();
        checks++;
        if (LEDS !== 5'b00001) begin errors++; $display("FAIL rotate_init got %b want 00001", LEDS); end
        for (int i = 0; i < 5; i++) begin
            n = 0;
            do begin cyc(); n++; end while (TICK !== 1'b1 && n < 2 * D);
            checks++;
            if (TICK !== 1'b1) begin errors++; $display("FAIL rotate_tick_timeout got %b want 1", TICK); end
            checks++;
            if (LEDS !== tbl[i]) begin errors++; $display("FAIL rotate_step%0d got %b want %b", i, LEDS, tbl[i]); end
        end
    endtask

    task automatic test_bounce();
        int tbl[10] = '{1, 2, 3, 4, 3, 2, 1, 0, 1, 2};
        logic [W-1:0] one;
        int n;
        one    = 1;
        MODE   = 2'd2;
        ENABLE = 1'b1;
        cyc(); cyc();
        checks++;
        if (LEDS !== one) begin errors++; $display("FAIL bounce_init got %b want %b", LEDS, one); end
        for (int i = 0; i < 10; i++) begin
            n = 0;
            do begin cyc(); n++; end while (TICK !== 1'b1 && n < 2 * D);
            checks++;
            if (LEDS !== (one << tbl[i])) begin errors++; $display("FAIL bounce_step%0d got %b want %b", i, LEDS, one << tbl[i]); end
        end
    endtask

    task automatic test_step();
        logic [W-1:0] base;
        int ntick;
        MODE   = 2'd0;
        ENABLE = 1'b1;
        cyc(); cyc();
        ENABLE = 1'b0;
        cyc();
        base = exp_leds;
        STEP = 1'b1;
        repeat (3) cyc();
        STEP = 1'b0;
        repeat (2) cyc();
        checks++;
        if (LEDS !== W'(base + 1)) begin errors++; $display("FAIL step_hold got %0d want %0d", LEDS, W'(base + 1)); end
        checks++;
        if (TICK !== 1'b0) begin errors++; $display("FAIL step_paused_tick got %b want 0", TICK); end
        repeat (2) begin STEP = 1'b1; cyc(); STEP = 1'b0; cyc(); end
        checks++;
        if (LEDS !== W'(base + 3)) begin errors++; $display("FAIL step_pulses got %0d want %0d", LEDS, W'(base + 3)); end
        ENABLE = 1'b1;
        ntick  = 0;
        for (int c = 0; c < 12; c++) begin
            STEP = ~STEP;
            cyc();
            if (TICK === 1'b1) ntick++;
        end
        STEP = 1'b0;
        checks++;
        if (ntick != 3) begin errors++; $display("FAIL step_enabled_ticks got %0d want 3", ntick); end
        checks++;
        if (LEDS !== W'(base + 3 + ntick)) begin errors++; $display("FAIL step_ignored got %0d want %0d", LEDS, W'(base + 3 + ntick)); end
    endtask

    task automatic test_simul();
        int n;
        MODE   = 2'd0;
        ENABLE = 1'b1;
        repeat (3) cyc();
        n = 0;
        while (m_pre != D - 2 && n < 2 * D) begin cyc(); n++; end
        MODE = 2'd2;
        cyc(); cyc();
        checks++;
        if (TICK !== 1'b1) begin errors++; $display("FAIL simul_tick got %b want 1", TICK); end
        checks++;
        if (LEDS !== 5'b00001) begin errors++; $display("FAIL simul_leds got %b want 00001", LEDS); end
    endtask

    task automatic test_breathe();
        int pulses[3] = '{2, 1, 1};
        int want[3]   = '{4, 6, 4};
        int on;
        int bad;
        MODE   = 2'd3;
        ENABLE = 1'b0;
        cyc(); cyc();
        bad = 0;
        repeat (4) begin cyc(); if (LEDS !== '0) bad++; end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL breathe_level0 got %0d lit cycles want 0", bad); end
        for (int p = 0; p < 3; p++) begin
            repeat (pulses[p]) begin STEP = 1'b1; cyc(); STEP = 1'b0; cyc(); end
            on  = 0;
            bad = 0;
            for (int c = 0; c < 8; c++) begin
                cyc();
                if (LEDS === 5'h1F) on++;
                else if (LEDS !== 5'h00) bad++;
            end
            checks++;
            if (on != want[p] || bad != 0) begin
                errors++;
                $display("FAIL breathe_duty%0d got %0d on (%0d bad) want %0d on of 8", p, on, bad, want[p]);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(15) == 0) MODE = 2'($urandom_range(3));
            if ($urandom_range(9) == 0) ENABLE = ~ENABLE;
            STEP = 1'($urandom_range(1));
            if (c == 200) begin
                #2 RESET = 1'b1;
                m_reset();
                #1;
                checks++;
                if (LEDS !== '0) begin errors++; $display("FAIL random_reset got %b want 0", LEDS); end
                @(negedge CLK);
                RESET = 1'b0;
            end
            cyc();
            checks++;
            if (LEDS !== exp_leds) begin errors++; $display("FAIL random_leds c=%0d got %b want %b", c, LEDS, exp_leds); end
            checks++;
            if (TICK !== exp_tick) begin errors++; $display("FAIL random_tick c=%0d got %b want %b", c, TICK, exp_tick); end
        end
    endtask

    initial begin
        m_reset();
        #2 RESET = 1'b1;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        test_reset();
        test_count();
        test_rotate();
        test_bounce();
        test_step();
        test_simul();
        test_breathe();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/led_sequencer.md
# led_sequencer

Parametrised LED pattern generator: successor to the fixed free-running LED counter in the blinky SoC. Derives a slow advance tick from the system clock with an internal prescaler and drives a WIDTH-bit LED bus in one of four selectable modes: binary count, rotate, bounce, and PWM breathe. Supports pause and single-step for board bring-up. Sits directly between the SoC clock/reset and the board LED pins.

## Interface

- WIDTH, 5, LED count; must be ≥ 2.
- DIV, 2000000, prescaler period in CLK cycles; must be ≥ 1.
- PWM_BITS, 4, breathe brightness resolution; level range 0..2^PWM_BITS-1.

Ports:

- CLK  in  1  system clock; all logic on rising edge.
- RESET  in  1  asynchronous, active-high; clears all state immediately.
- MODE  in  2  pattern select: 0 COUNT, 1 ROTATE, 2 BOUNCE, 3 BREATHE. Synchronous to CLK.
- ENABLE  in  1  1 = prescaler runs and ticks advance the pattern; 0 = paused.
- STEP  in  1  level input; a rising edge while ENABLE=0 advances the pattern once.
- LEDS  out  WIDTH  registered LED drive, active-high.
- TICK  out  1  registered one-cycle strobe on each prescaler wrap.

## Operation

Reset values:
- LEDS=0, TICK=0, prescaler=0, mode_q=0, count=0.
- pos=0, dir=up, level=0, level_dir=up, pwm_cnt=0, step_q=0.

Prescaler:
- Counts 0..DIV-1 while ENABLE=1; holds its value while ENABLE=0.
- When it is at DIV-1 with ENABLE=1: it wraps to 0 and TICK=1 in the next cycle.
- DIV=1: TICK is high every cycle while ENABLE=1.

Advance event (adv), a combinational signal in cycle N:
- (prescaler==DIV-1 && ENABLE), or
- (STEP && !step_q && !ENABLE).
- step_q registers STEP every cycle.
- STEP edges while ENABLE=1 are ignored.

Mode change:
- mode_q registers MODE.
- If MODE != mode_q in a cycle, that cycle re-initialises the selected mode's state and ignores adv (mode change wins over a simultaneous advance).
- Re-init state:
  - COUNT: count=0.
  - ROTATE: onehot=1.
  - BOUNCE: pos=0, dir=up.
  - BREATHE: level=0, level_dir=up.

Per-mode behaviour on adv:
- COUNT: count = count+1, modulo 2^WIDTH (WIDTH-bit wrap). LEDS=count.
- ROTATE: onehot rotated left by one; bit WIDTH-1 moves to bit 0. LEDS=onehot.
- BOUNCE: LEDS = 1<<pos.
  - Going up: pos+1; when the new pos==WIDTH-1, dir becomes down.
  - Going down: pos-1; when the new pos==0, dir becomes up.
  - The end LEDs are lit for exactly one step; sequence for WIDTH=5: 0,1,2,3,4,3,2,1,0,1…
- BREATHE: level follows a triangle wave 0→max→0.
  - Endpoints are reached once per pass, with the same turnaround rule as BOUNCE.
  - pwm_cnt (PWM_BITS wide) free-runs +1 every CLK in all modes.
  - LEDS = all-ones when pwm_cnt < level, else 0. level=0 gives LEDS permanently 0.

Other rules:
- Entering BREATHE after reset (mode_q starts at 0): level=0, so LEDS=0 until the first adv.
- Reset asserted mid-pattern returns to the reset values asynchronously.
- After RESET deasserts, the first CLK edge restarts the prescaler from 0.

## Timing

- adv in cycle N: new pattern visible on LEDS after the edge ending cycle N (one-cycle latency).
- First TICK after reset with ENABLE=1 held: high in cycle DIV+1 (cycles counted from the first edge after reset release). It recurs every DIV cycles.
- Mode change: MODE changes before edge E. mode_q updates at E. The re-init is applied at edge E+1, and the LEDS re-init value is visible after E+1.
- BREATHE PWM period = 2^PWM_BITS CLK cycles. The LEDS compare is registered, so LEDS lags pwm_cnt by one cycle.
- TICK depends only on the prescaler; it is unaffected by mode and STEP.

## Test plan

Bench parameters: WIDTH=5, DIV=4, PWM_BITS=2.

- Reset/COUNT:
  - Stimulus: assert RESET mid-cycle, release, set ENABLE=1, MODE=0.
  - Required: LEDS=0 immediately on RESET; TICK every 4 cycles.
  - Required: LEDS steps 1,2,3…31,0, changing one cycle after each wrap (wrap at 31→0 confirmed).
- ROTATE:
  - Stimulus: MODE=1, ENABLE=1.
  - Required: LEDS=00001 after the re-init.
  - Required: successive ticks give 00010, 00100, 01000, 10000, 00001.
- BOUNCE:
  - Stimulus: MODE=2, ENABLE=1, run 10 ticks.
  - Required: LED index sequence 0,1,2,3,4,3,2,1,0,1,2.
- Pause/step:
  - Stimulus: MODE=0, ENABLE=0, TICK absent; hold STEP high for 3 cycles, then low; then pulse STEP twice.
  - Required: 3-cycle high gives exactly +1.
  - Required: two pulses give +2 total.
  - Required: STEP pulses with ENABLE=1 give no extra advance.
- Simultaneous mode change and tick:
  - Stimulus: switch MODE 0→2 so the re-init edge coincides with a prescaler wrap.
  - Required: LEDS=00001 (pos 0); the tick is not applied.
- BREATHE:
  - Stimulus: MODE=3; advance level to 2.
  - Required: LEDS all-ones for 2 of every 4 cycles.
  - Required: at level=3, all-ones for 3 of 4.
  - Required: the next adv returns level to 2.
